fp_operand_unpack: RTL and testbench

Parametrised, handshaked operand-unpack stage at the front of the floating-point unit. It accepts two IEEE-754 operands and an operation code for add, sub, mul or div, and produces, one cycle later, everything the downstream align/multiply/divide stages need. That covers:

- fields and mantissas with the correct hidden bit,
- effective operation,
- signed exponent difference and mantissa compare,
- biased mul/div exponent,
- per-operand class flags and early exception flags.

A 2-entry output buffer decouples upstream from downstream stalls.

---
 rtl/fp_operand_unpack.sv | 192 +++++++++++++++++++
 tb/tb_fp_operand_unpack.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_unpack.sv
// Front-end unpack stage of the FPU: splits two IEEE-754 operands into fields, classifies them,
// precomputes align/mul/div quantities and early exceptions, and buffers results in a 2-entry FIFO.
module fp_operand_unpack #(
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    parameter int DataSize     = 1 + ExponentSize + FractionSize,
    parameter int Bias         = (1 << (ExponentSize - 1)) - 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DataSize-1:0]       Operand1,
    input  logic [DataSize-1:0]       Operand2,
    input  logic [1:0]                Operation,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [1:0]                OutOperation,
    output logic                      Sign1,
    output logic                      Sign2,
    output logic [ExponentSize-1:0]   Exponent1,
    output logic [ExponentSize-1:0]   Exponent2,
    output logic [FractionSize:0]     Mantissa1,
    output logic [FractionSize:0]     Mantissa2,
    output logic                      EffOperation,
    output logic                      ResultSign,
    output logic [ExponentSize-1:0]   Difference,
    output logic                      SignOfDifference,
    output logic                      ZeroDifference,
    output logic [1:0]                Compare,
    output logic [ExponentSize+1:0]   MDExponent,
    output logic [3:0]                Class1,
    output logic [3:0]                Class2,
    output logic                      Invalid,
    output logic                      DivByZero
);
    localparam int EW = ExponentSize;
    localparam int FW = FractionSize;
    localparam int XW = ExponentSize + 2;
    localparam logic [XW-1:0] BiasX = XW'(Bias);

    typedef struct packed {
        logic [1:0]    op;
        logic          s1;
        logic          s2;
        logic [EW-1:0] e1;
        logic [EW-1:0] e2;
        logic [FW:0]   m1;
        logic [FW:0]   m2;
        logic          eff;
        logic          rs;
        logic [EW-1:0] diff;
        logic          sod;
        logic          zd;
        logic [1:0]    cmp;
        logic [XW-1:0] mde;
        logic [3:0]    c1;
        logic [3:0]    c2;
        logic          inv;
        logic          dbz;
    } res_t;

    // {NaN, Inf, Zero, Denormal}; all zero means a normal number
    function automatic logic [3:0] classify(input logic [EW-1:0] e, input logic [FW-1:0] f);
        logic emax, ezero, fzero;
        emax  = &e;
        ezero = (e == '0);
        fzero = (f == '0);
        return {emax & ~fzero, emax & fzero, ezero & fzero, ezero & ~fzero};
    endfunction

    logic [EW-1:0] raw_exp1, raw_exp2;
    logic [FW-1:0] frac1, frac2;
    logic [EW:0]   exp_sub;
    logic          is_addsub, is_mul, is_div;
    res_t          push_res;

    assign raw_exp1  = Operand1[DataSize-2 -: EW];
    assign raw_exp2  = Operand2[DataSize-2 -: EW];
    assign frac1     = Operand1[FW-1:0];
    assign frac2     = Operand2[FW-1:0];
    assign is_addsub = ~Operation[1];
    assign is_mul    = (Operation == 2'b10);
    assign is_div    = (Operation == 2'b11);

    always_comb begin
        push_res      = '0;
        push_res.op   = Operation;
        push_res.s1   = Operand1[DataSize-1];
        push_res.s2   = Operand2[DataSize-1];
        push_res.e1   = (raw_exp1 == '0) ? EW'(1) : raw_exp1;
        push_res.e2   = (raw_exp2 == '0) ? EW'(1) : raw_exp2;
        push_res.m1   = {raw_exp1 != '0, frac1};
        push_res.m2   = {raw_exp2 != '0, frac2};
        push_res.c1   = classify(raw_exp1, frac1);
        push_res.c2   = classify(raw_exp2, frac2);
        push_res.eff  = is_addsub & (Operation[0] ^ push_res.s1 ^ push_res.s2);
        push_res.rs   = Operation[1] & (push_res.s1 ^ push_res.s2);

        // one extra bit holds the borrow, which doubles as the sign of the difference
        exp_sub       = {1'b0, push_res.e1} - {1'b0, push_res.e2};
        push_res.sod  = exp_sub[EW];
        push_res.diff = exp_sub[EW] ? EW'(-exp_sub) : exp_sub[EW-1:0];
        push_res.zd   = (push_res.e1 == push_res.e2);

        if (push_res.m1 == push_res.m2)     push_res.cmp = 2'b00;
        else if (push_res.m1 > push_res.m2) push_res.cmp = 2'b01;
        else                                push_res.cmp = 2'b10;

        if (is_mul)      push_res.mde = XW'(push_res.e1) + XW'(push_res.e2) - BiasX;
        else if (is_div) push_res.mde = XW'(push_res.e1) - XW'(push_res.e2) + BiasX;

        push_res.inv = push_res.c1[3] | push_res.c2[3]
                     | (is_addsub & push_res.c1[2] & push_res.c2[2] & push_res.eff)
                     | (is_mul & ((push_res.c1[1] & push_res.c2[2]) | (push_res.c1[2] & push_res.c2[1])))
                     | (is_div & ((push_res.c1[1] & push_res.c2[1]) | (push_res.c1[2] & push_res.c2[2])));
        push_res.dbz = is_div & ~push_res.c1[3] & ~push_res.c1[2] & ~push_res.c1[1] & push_res.c2[1];
    end

    res_t       head_q, head_d, tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    assign push = InValid & in_ready_q;
    assign pop  = out_valid_q & OutReady;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_res;
                else                 tail_d = push_res;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) head_d = push_res;
                else begin
                    head_d = tail_q;
                    tail_d = push_res;
                end
            end
            default: ;
        endcase
        out_valid_d = (count_d != 2'd0);
        in_ready_d  = (count_d < 2'd2);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign InReady          = in_ready_q;
    assign OutValid         = out_valid_q;
    assign OutOperation     = head_q.op;
    assign Sign1            = head_q.s1;
    assign Sign2            = head_q.s2;
    assign Exponent1        = head_q.e1;
    assign Exponent2        = head_q.e2;
    assign Mantissa1        = head_q.m1;
    assign Mantissa2        = head_q.m2;
    assign EffOperation     = head_q.eff;
    assign ResultSign       = head_q.rs;
    assign Difference       = head_q.diff;
    assign SignOfDifference = head_q.sod;
    assign ZeroDifference   = head_q.zd;
    assign Compare          = head_q.cmp;
    assign MDExponent       = head_q.mde;
    assign Class1           = head_q.c1;
    assign Class2           = head_q.c2;
    assign Invalid          = head_q.inv;
    assign DivByZero        = head_q.dbz;
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Single-precision bench for fp_operand_unpack: directed scenarios plus a scoreboard that
// predicts every accepted operand pair and checks it when the FIFO head is popped.
module tb_fp_operand_unpack;
    typedef struct packed {
        logic [1:0]  op;
        logic        s1;
        logic        s2;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [23:0] m1;
        logic [23:0] m2;
        logic        eff;
        logic        rs;
        logic [7:0]  diff;
        logic        sod;
        logic        zd;
        logic [1:0]  cmp;
        logic [9:0]  mde;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic        inv;
        logic        dbz;
    } res_t;

    logic        Clock = 1'b0, Reset = 1'b1;
    logic        InValid = 1'b0, OutReady = 1'b0;
    logic [31:0] Operand1 = '0, Operand2 = '0;
    logic [1:0]  Operation = '0;
    logic        InReady, OutValid, Sign1, Sign2, EffOperation, ResultSign;
    logic        SignOfDifference, ZeroDifference, Invalid, DivByZero;
    logic [1:0]  OutOperation, Compare;
    logic [7:0]  Exponent1, Exponent2, Difference;
    logic [23:0] Mantissa1, Mantissa2;
    logic [9:0]  MDExponent;
    logic [3:0]  Class1, Class2;

    int   checks = 0, errors = 0, pops = 0;
    res_t sb[$];
    res_t obs, mon_exp, held;

    fp_operand_unpack dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Operand1(Operand1), .Operand2(Operand2), .Operation(Operation),
        .OutValid(OutValid), .OutReady(OutReady), .OutOperation(OutOperation),
        .Sign1(Sign1), .Sign2(Sign2), .Exponent1(Exponent1), .Exponent2(Exponent2),
        .Mantissa1(Mantissa1), .Mantissa2(Mantissa2), .EffOperation(EffOperation),
        .ResultSign(ResultSign), .Difference(Difference), .SignOfDifference(SignOfDifference),
        .ZeroDifference(ZeroDifference), .Compare(Compare), .MDExponent(MDExponent),
        .Class1(Class1), .Class2(Class2), .Invalid(Invalid), .DivByZero(DivByZero)
    );

    always #5 Clock = ~Clock;

    assign obs = {OutOperation, Sign1, Sign2, Exponent1, Exponent2, Mantissa1, Mantissa2,
                  EffOperation, ResultSign, Difference, SignOfDifference, ZeroDifference,
                  Compare, MDExponent, Class1, Class2, Invalid, DivByZero};

    function automatic logic [3:0] cls(input int e, input logic [22:0] f);
        if (e == 255) return (f != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (f != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        res_t r;
        int ra, rb, ea, eb, d, ad, md;
        r    = '0;
        ra   = int'(a[30:23]);
        rb   = int'(b[30:23]);
        ea   = (ra == 0) ? 1 : ra;
        eb   = (rb == 0) ? 1 : rb;
        r.op = op;
        r.s1 = a[31];
        r.s2 = b[31];
        r.e1 = ea[7:0];
        r.e2 = eb[7:0];
        r.m1 = {(ra != 0), a[22:0]};
        r.m2 = {(rb != 0), b[22:0]};
        r.c1 = cls(ra, a[22:0]);
        r.c2 = cls(rb, b[22:0]);
        d    = ea - eb;
        ad   = (d < 0) ? -d : d;
        r.diff = ad[7:0];
        r.sod  = (d < 0);
        r.zd   = (d == 0);
        r.cmp  = (r.m1 == r.m2) ? 2'b00 : ((r.m1 > r.m2) ? 2'b01 : 2'b10);
        r.eff  = (op < 2) ? (a[31] ^ b[31] ^ op[0]) : 1'b0;
        r.rs   = (op >= 2) ? (a[31] ^ b[31]) : 1'b0;
        md     = (op == 2) ? ea + eb - 127 : ((op == 3) ? ea - eb + 127 : 0);
        r.mde  = md[9:0];
        r.inv  = (r.c1 == 4'b1000) || (r.c2 == 4'b1000)
              || (op < 2 && r.c1 == 4'b0100 && r.c2 == 4'b0100 && r.eff)
              || (op == 2 && ((r.c1 == 4'b0010 && r.c2 == 4'b0100) || (r.c1 == 4'b0100 && r.c2 == 4'b0010)))
              || (op == 3 && ((r.c1 == 4'b0010 && r.c2 == 4'b0010) || (r.c1 == 4'b0100 && r.c2 == 4'b0100)));
        r.dbz  = (op == 3) && (r.c1 == 4'b0000 || r.c1 == 4'b0001) && (r.c2 == 4'b0010);
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom % 5)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'd127;
            default: e = 8'($urandom);
        endcase
        f = ($urandom % 3 == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Scoreboard: inputs and outputs are stable at the falling edge; handshakes complete at the next rising edge.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (OutValid && OutReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pop got %h", obs);
                end else begin
                    mon_exp = sb.pop_front();
                    pops++;
                    if (obs !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_result got %h expected %h", obs, mon_exp);
                    end
                end
            end
            if (InValid && InReady) sb.push_back(model(Operand1, Operand2, Operation));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic done;
        done      = 1'b0;
        Operand1  = a;
        Operand2  = b;
        Operation = op;
        InValid   = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            if (InReady) done = 1'b1;
            tick();
        end
        InValid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got InReady=%0b expected 1", InReady);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %0b expected 0", OutValid); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready got %0b expected 0", InReady); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", obs); end
        Reset = 1'b0;
        OutReady = 1'b1;
        tick();
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_release_inready got %0b expected 1", InReady); end
    endtask

    task automatic test_add();
        send(32'h3F800000, 32'h40000000, 2'b00);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_outvalid got %0b expected 1", OutValid); end
        checks++; if ({Exponent1, Exponent2} !== {8'd127, 8'd128}) begin errors++; $display("FAIL add_exponents got %0d,%0d expected 127,128", Exponent1, Exponent2); end
        checks++; if ({Difference, SignOfDifference, ZeroDifference} !== {8'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL add_difference got %0d/%0b/%0b expected 1/1/0", Difference, SignOfDifference, ZeroDifference); end
        checks++; if ({Compare, EffOperation} !== 3'b000) begin errors++; $display("FAIL add_cmp_eff got %b/%b expected 00/0", Compare, EffOperation); end
    endtask

    task automatic test_sub();
        send(32'h3F800000, 32'hBF800000, 2'b01);
        checks++; if ({EffOperation, Sign2} !== 2'b01) begin errors++; $display("FAIL sub_eff_sign2 got %b%b expected 01", EffOperation, Sign2); end
        send(32'h3F800000, 32'hBF800000, 2'b00);
        checks++; if (EffOperation !== 1'b1) begin errors++; $display("FAIL add_neg_eff got %b expected 1", EffOperation); end
    endtask

    task automatic test_muldiv();
        send(32'h40000000, 32'h40400000, 2'b10);
        checks++; if ({MDExponent, ResultSign} !== {10'd129, 1'b0}) begin errors++; $display("FAIL mul_mdexp got %0d/%b expected 129/0", MDExponent, ResultSign); end
        send(32'h3F800000, 32'h80000000, 2'b11);
        checks++; if ({DivByZero, Invalid} !== 2'b10) begin errors++; $display("FAIL div_zero_flags got %b%b expected 10", DivByZero, Invalid); end
        checks++; if ({Class2, ResultSign} !== {4'b0010, 1'b1}) begin errors++; $display("FAIL div_zero_class got %b/%b expected 0010/1", Class2, ResultSign); end
        checks++; if (MDExponent !== 10'd253) begin errors++; $display("FAIL div_mdexp got %0d expected 253", MDExponent); end
    endtask

    task automatic test_specials();
        send(32'h7F800000, 32'h7F800000, 2'b01);
        checks++; if (Invalid !== 1'b1) begin errors++; $display("FAIL inf_minus_inf got %b expected 1", Invalid); end
        send(32'h00000001, 32'h00800000, 2'b00);
        checks++; if ({Class1, Exponent1, Mantissa1} !== {4'b0001, 8'd1, 24'h000001}) begin errors++; $display("FAIL denorm_fields got %b/%0d/%h expected 0001/1/000001", Class1, Exponent1, Mantissa1); end
        checks++; if ({ZeroDifference, Compare} !== 3'b110) begin errors++; $display("FAIL denorm_cmp got %b/%b expected 1/10", ZeroDifference, Compare); end
    endtask

    task automatic test_backpressure();
        res_t ra, rb, rc;
        int   p0;
        tick();
        ra = model(32'h3F800000, 32'h40000000, 2'b00);
        rb = model(32'hC0400000, 32'h3F000000, 2'b10);
        rc = model(32'h41200000, 32'h7FC00000, 2'b11);
        OutReady  = 1'b0;
        InValid   = 1'b1;
        Operand1  = 32'h3F800000; Operand2 = 32'h40000000; Operation = 2'b00;
        tick();
        Operand1  = 32'hC0400000; Operand2 = 32'h3F000000; Operation = 2'b10;
        tick();
        Operand1  = 32'h41200000; Operand2 = 32'h7FC00000; Operation = 2'b11;
        checks++; if ({InReady, OutValid} !== 2'b01) begin errors++; $display("FAIL bp_full got InReady=%b OutValid=%b expected 0/1", InReady, OutValid); end
        checks++; if (obs !== ra) begin errors++; $display("FAIL bp_head got %h expected %h", obs, ra); end
        held = obs;
        repeat (3) tick();
        checks++; if (obs !== held || InReady !== 1'b0) begin errors++; $display("FAIL bp_stable got %h/%b expected %h/0", obs, InReady, held); end
        p0 = pops;
        OutReady = 1'b1;
        tick();
        checks++; if (InReady !== 1'b1 || obs !== rb) begin errors++; $display("FAIL bp_second got %h/%b expected %h/1", obs, InReady, rb); end
        tick();
        InValid = 1'b0;
        checks++; if (OutValid !== 1'b1 || obs !== rc) begin errors++; $display("FAIL bp_third got %h/%b expected %h/1", obs, OutValid, rc); end
        tick();
        checks++; if (OutValid !== 1'b0 || pops - p0 != 3) begin errors++; $display("FAIL bp_drain got OutValid=%b pops=%0d expected 0/3", OutValid, pops - p0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            Operand1  = rand_fp();
            Operand2  = rand_fp();
            Operation = 2'($urandom);
            InValid   = ($urandom % 4) != 0;
            OutReady  = ($urandom % 3) != 0;
            tick();
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int t = 0; t < 10 && sb.size() != 0; t++) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL random_drain got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        OutReady = 1'b0;
        InValid  = 1'b1;
        Operand1 = 32'h40490FDB; Operand2 = 32'h3F800000; Operation = 2'b00;
        tick();
        Operand1 = 32'hC1000000; Operation = 2'b11;
        tick();
        InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        checks++; if ({OutValid, InReady} !== 2'b00) begin errors++; $display("FAIL rst_mid_ctrl got %b%b expected 00", OutValid, InReady); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h expected 0", obs); end
        sb.delete();
        tick();
        Reset = 1'b0;
        OutReady = 1'b1;
        tick();
        checks++; if ({InReady, OutValid} !== 2'b10) begin errors++; $display("FAIL rst_mid_release got %b%b expected 10", InReady, OutValid); end
        repeat (3) tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got %b expected 0", OutValid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_muldiv();
        test_specials();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end
endmodule
